// File: rtl/digit_scan_pkg.sv
// -----------------------------------------------------------------------------
// digit_scan_pkg
// Shared types and constants for the four-digit BCD counter with multiplexed
// seven-segment scan output.
//   bcd_t        : one BCD digit (4 bits)
//   scan_idx_t   : scan slot index (2 bits, slots 0..3)
//   SEL_OFF      : active-low digit select with every digit dark
//   DIGITS       : number of BCD digits in the counter
// -----------------------------------------------------------------------------
package digit_scan_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [1:0] scan_idx_t;

    localparam logic [3:0] SEL_OFF = 4'b1111;
    localparam int         DIGITS  = 4;

    // Nibbles that are not valid BCD are stored as zero.
    function automatic bcd_t bcd_sanitize(input logic [3:0] nib);
        return (nib > 4'd9) ? 4'd0 : nib;
    endfunction

    // Active-low one-hot select for a scan slot.
    function automatic logic [3:0] sel_onehot_n(input scan_idx_t idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/digit_scan_bcd_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
// One decade of an up/down BCD counter. Chained so that each digit's en_in is
// the carry/borrow of the digit below it, giving a same-cycle ripple.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   en_in    : step this digit this cycle
//   up       : 1 = increment, 0 = decrement
//   load     : load ld_val (takes priority over en_in)
//   ld_val   : value to load; nibbles above 9 are stored as 0
//   digit    : current registered digit
//   co       : carry (up, digit==9) or borrow (down, digit==0) while enabled
// -----------------------------------------------------------------------------
module bcd_digit
    import digit_scan_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en_in,
    input  logic up,
    input  logic load,
    input  bcd_t ld_val,
    output bcd_t digit,
    output logic co
);

    bcd_t digit_q;
    bcd_t digit_d;

    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = bcd_sanitize(ld_val);
        end else if (en_in) begin
            if (up) begin
                digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
            end else begin
                digit_d = (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
            end
        end
    end

    // Carry/borrow is combinational so the next digit steps in the same cycle.
    assign co = en_in && (up ? (digit_q == 4'd9) : (digit_q == 4'd0));

    always_ff @(posedge clk) begin
        if (rst) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit = digit_q;

endmodule

// File: rtl/digit_scan.sv
// -----------------------------------------------------------------------------
// digit_scan
// Four-digit BCD up/down counter with a time-multiplexed digit scan for a
// common seven-segment display.
// Parameters:
//   SCAN_DIV : clock cycles per displayed digit slot (2 .. 2**20)
//   BLANK_LZ : 1 = blank leading-zero digits, 0 = show all four digits
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   en, up   : count enable and direction (1 = up)
//   load     : synchronous load of load_val (priority over en)
//   load_val : four BCD digits, [3:0] = units
//   value    : current count, four BCD digits, [3:0] = units
//   carry    : one-cycle pulse when the count wraps 9999<->0000
//   data     : BCD digit currently being displayed (registered)
//   sel      : active-low one-hot digit select, 4'b1111 = dark (registered)
// -----------------------------------------------------------------------------
module digit_scan
    import digit_scan_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int BLANK_LZ = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        up,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] value,
    output logic        carry,
    output logic [3:0]  data,
    output logic [3:0]  sel
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    // -------------------------------------------------------------------------
    // Counter: four chained decades
    // -------------------------------------------------------------------------
    bcd_t              digits [DIGITS];
    logic [DIGITS-1:0] co;
    logic [DIGITS-1:0] en_chain;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        if (k == 0) begin : g_first
            assign en_chain[k] = en;
        end else begin : g_rest
            assign en_chain[k] = co[k-1];
        end

        bcd_digit u_digit (
            .clk    (clk),
            .rst    (rst),
            .en_in  (en_chain[k]),
            .up     (up),
            .load   (load),
            .ld_val (load_val[4*k +: 4]),
            .digit  (digits[k]),
            .co     (co[k])
        );
    end

    assign value = {digits[3], digits[2], digits[1], digits[0]};

    // Wrap happens when the top decade carries/borrows; a load overrides it.
    logic carry_q;
    logic carry_d;

    assign carry_d = co[DIGITS-1] && !load;

    // -------------------------------------------------------------------------
    // Scan: prescaler, slot index, blanking, registered data/sel
    // -------------------------------------------------------------------------
    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;
    scan_idx_t     idx_q;
    scan_idx_t     idx_d;
    logic [3:0]    data_q;
    logic [3:0]    data_d;
    logic [3:0]    sel_q;
    logic [3:0]    sel_d;
    logic          pre_term;

    // upper_zero[i] : digit i and every digit above it are zero.
    logic [DIGITS-1:0] upper_zero;

    assign pre_term = (pre_q == PW'(SCAN_DIV - 1));

    always_comb begin
        pre_d = pre_q + PW'(1);
        idx_d = idx_q;
        if (pre_term) begin
            pre_d = '0;
            idx_d = idx_q + 2'd1;
        end
    end

    always_comb begin
        upper_zero[DIGITS-1] = (digits[DIGITS-1] == 4'd0);
        for (int i = DIGITS - 2; i >= 0; i--) begin
            upper_zero[i] = upper_zero[i+1] && (digits[i] == 4'd0);
        end
    end

    // Slot 0 is never blanked so a zero count still shows a single "0".
    always_comb begin
        data_d = digits[idx_q];
        sel_d  = sel_onehot_n(idx_q);
        if ((BLANK_LZ != 0) && (idx_q != 2'd0) && upper_zero[idx_q]) begin
            sel_d = SEL_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q   <= '0;
            idx_q   <= 2'd0;
            data_q  <= 4'h0;
            sel_q   <= SEL_OFF;
            carry_q <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            carry_q <= carry_d;
        end
    end

    assign carry = carry_q;
    assign data  = data_q;
    assign sel   = sel_q;

endmodule

// File: tb/tb_digit_scan.sv
module tb_digit_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        up;
    logic        load;
    logic [15:0] load_val;

    logic [15:0] value_b, value_n;
    logic        carry_b, carry_n;
    logic [3:0]  data_b,  data_n;
    logic [3:0]  sel_b,   sel_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Leading-zero blanking enabled
    digit_scan #(.SCAN_DIV(4), .BLANK_LZ(1)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .value(value_b), .carry(carry_b), .data(data_b), .sel(sel_b)
    );

    // All digits always shown
    digit_scan #(.SCAN_DIV(4), .BLANK_LZ(0)) dut_nb (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .value(value_n), .carry(carry_n), .data(data_n), .sel(sel_n)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reset for one cycle, release (optionally loading lv on the release cycle),
    // then check 16 cycles of scan on both instances against per-slot tables.
    task automatic scan_run(input logic do_load, input logic [15:0] lv,
                            input logic [3:0] sb [4], input logic [3:0] db [4],
                            input logic [3:0] sn [4], input logic [3:0] dn [4]);
        int slot;
        rst = 1'b1; load = 1'b0; en = 1'b0;
        step();
        chk("scan_rst_sel", {12'h0, sel_b}, 16'h000f);
        rst = 1'b0; load = do_load; load_val = lv;
        for (int k = 1; k <= 16; k++) begin
            step();
            load = 1'b0;
            slot = (k - 1) / 4;
            chk($sformatf("sel_blank_k%0d", k), {12'h0, sel_b}, {12'h0, sb[slot]});
            chk($sformatf("data_blank_k%0d", k), {12'h0, data_b}, {12'h0, db[slot]});
            chk($sformatf("sel_all_k%0d", k), {12'h0, sel_n}, {12'h0, sn[slot]});
            chk($sformatf("data_all_k%0d", k), {12'h0, data_n}, {12'h0, dn[slot]});
        end
    endtask

    logic [3:0] sb [4];
    logic [3:0] db [4];
    logic [3:0] sn [4];
    logic [3:0] dn [4];

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_val = 16'h0000;

        // Reset held three cycles
        step(); step(); step();
        chk("rst_value", value_b, 16'h0000);
        chk("rst_carry", {15'h0, carry_b}, 16'h0000);
        chk("rst_sel", {12'h0, sel_b}, 16'h000f);
        chk("rst_data", {12'h0, data_b}, 16'h0000);
        chk("rst_sel_nb", {12'h0, sel_n}, 16'h000f);

        // Zero count scan: only units digit lit when blanking
        sb = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
        db = '{4'h0, 4'h0, 4'h0, 4'h0};
        sn = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        dn = '{4'h0, 4'h0, 4'h0, 4'h0};
        scan_run(1'b0, 16'h0000, sb, db, sn, dn);

        // Up-count across the 9999 -> 0000 wrap
        load = 1'b1; load_val = 16'h9998;
        step();
        chk("ld9998_value", value_b, 16'h9998);
        chk("ld9998_carry", {15'h0, carry_b}, 16'h0000);
        load = 1'b0; en = 1'b1; up = 1'b1;
        step();
        chk("up1_value", value_b, 16'h9999);
        chk("up1_carry", {15'h0, carry_b}, 16'h0000);
        step();
        chk("up2_value", value_b, 16'h0000);
        chk("up2_carry", {15'h0, carry_b}, 16'h0001);
        step();
        chk("up3_value", value_b, 16'h0001);
        chk("up3_carry", {15'h0, carry_b}, 16'h0000);
        en = 1'b0;
        step();
        chk("hold_value", value_b, 16'h0001);
        chk("hold_carry", {15'h0, carry_b}, 16'h0000);

        // Down-count across the 0000 -> 9999 wrap
        load = 1'b1; load_val = 16'h0000;
        step();
        chk("ld0000_value", value_b, 16'h0000);
        load = 1'b0; en = 1'b1; up = 1'b0;
        step();
        chk("dn_wrap_value", value_b, 16'h9999);
        chk("dn_wrap_carry", {15'h0, carry_b}, 16'h0001);
        en = 1'b0;
        step();
        chk("dn_after_value", value_b, 16'h9999);
        chk("dn_after_carry", {15'h0, carry_b}, 16'h0000);

        // Load beats en and never pulses carry, even at 9999 counting up
        load = 1'b1; load_val = 16'h9999; en = 1'b1; up = 1'b1;
        step();
        chk("ld_pri_value", value_b, 16'h9999);
        chk("ld_pri_carry", {15'h0, carry_b}, 16'h0000);

        // Ripple carry and borrow through several digits
        load_val = 16'h0199; en = 1'b0;
        step();
        load = 1'b0; en = 1'b1; up = 1'b1;
        step();
        chk("ripple_up", value_b, 16'h0200);
        load = 1'b1; load_val = 16'h1000; en = 1'b0;
        step();
        load = 1'b0; en = 1'b1; up = 1'b0;
        step();
        chk("ripple_dn", value_b, 16'h0999);
        chk("ripple_dn_carry", {15'h0, carry_b}, 16'h0000);
        en = 1'b0;

        // Invalid BCD nibbles load as zero; scan shows 0050
        sb = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
        db = '{4'h0, 4'h5, 4'h0, 4'h0};
        sn = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        dn = '{4'h0, 4'h5, 4'h0, 4'h0};
        scan_run(1'b1, 16'h0A5F, sb, db, sn, dn);
        chk("ld0A5F_value", value_b, 16'h0050);

        // 0120: interior zero digit is not blanked
        sb = '{4'b1110, 4'b1101, 4'b1011, 4'b1111};
        db = '{4'h0, 4'h2, 4'h1, 4'h0};
        sn = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        dn = '{4'h0, 4'h2, 4'h1, 4'h0};
        scan_run(1'b1, 16'h0120, sb, db, sn, dn);
        chk("ld0120_value", value_n, 16'h0120);

        // Reset during scan slot 2 with value 0500 while counting
        rst = 1'b1;
        step();
        rst = 1'b0; load = 1'b1; load_val = 16'h0500;
        for (int k = 1; k <= 10; k++) begin
            step();
            load = 1'b0;
        end
        chk("slot2_sel", {12'h0, sel_b}, 16'h000b);
        chk("slot2_data", {12'h0, data_b}, 16'h0005);
        en = 1'b1; up = 1'b1;
        rst = 1'b1;
        step();
        chk("midrst_value", value_b, 16'h0000);
        chk("midrst_sel", {12'h0, sel_b}, 16'h000f);
        chk("midrst_carry", {15'h0, carry_b}, 16'h0000);
        chk("midrst_data", {12'h0, data_b}, 16'h0000);
        en = 1'b0; rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("restart_slot0_k%0d", k), {12'h0, sel_n}, 16'h000e);
        end
        step();
        chk("restart_slot1_nb", {12'h0, sel_n}, 16'h000d);
        chk("restart_slot1_blank", {12'h0, sel_b}, 16'h000f);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
